vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_pkg.sv | 26 ++
 rtl/vga_timing_gen_if.sv | 35 +++
 rtl/vga_pattern_gen.sv | 151 +++++++++++++++
 rtl/vga_timing_gen.sv | 156 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA timing generator: the test-pattern encodings
// and the helper that sizes the position counters from a timing total.
// -----------------------------------------------------------------------------
package vga_pkg;

    // Test-pattern selector encodings (value of the 2-bit pattern input).
    typedef enum logic [1:0] {
        PAT_BLACK   = 2'd0,
        PAT_BARS    = 2'd1,
        PAT_CHECKER = 2'd2,
        PAT_RED     = 2'd3
    } pattern_t;

    // Bits needed to count 0..total-1; never less than one bit so that
    // degenerate totals (1 or 2) still yield a legal vector.
    function automatic int cnt_width(input int total);
        if (total <= 2) begin
            return 1;
        end else begin
            return $clog2(total);
        end
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// -----------------------------------------------------------------------------
// vga_timing_gen_if
// Video output bundle of the timing generator.
//   hsync, vsync     : sync pulses
//   de               : active-video flag
//   col, row         : current pixel position
//   frame_start      : one-clock pulse at pixel (0,0)
//   red, grn, blu    : pixel colour
// master = generator side (drives), slave = display/consumer side.
// -----------------------------------------------------------------------------
interface vga_timing_gen_if #(
    parameter int COL_W       = 10,
    parameter int ROW_W       = 10,
    parameter int VIDEO_WIDTH = 4
) ();

    logic                   hsync;
    logic                   vsync;
    logic                   de;
    logic [COL_W-1:0]       col;
    logic [ROW_W-1:0]       row;
    logic                   frame_start;
    logic [VIDEO_WIDTH-1:0] red;
    logic [VIDEO_WIDTH-1:0] grn;
    logic [VIDEO_WIDTH-1:0] blu;

    modport master (
        output hsync, vsync, de, col, row, frame_start, red, grn, blu
    );

    modport slave (
        input  hsync, vsync, de, col, row, frame_start, red, grn, blu
    );

endinterface

// File: rtl/vga_pattern_gen.sv
// -----------------------------------------------------------------------------
// vga_pattern_gen
// Colour generator. Works on the *next* pixel position supplied by the timing
// core so its registered colour lines up with the registered sync/position.
//   clk, reset   : clock, synchronous active-high reset
//   strobe       : pixel advance (position inputs are valid as next values)
//   line_wrap    : this strobe moves col to 0
//   frame_wrap   : this strobe moves (col,row) to (0,0); pattern is latched
//   col_nx,row_nx: position after this strobe
//   de_nx        : active-video flag after this strobe
//   pattern      : requested pattern (sampled only at frame_wrap)
//   red,grn,blu  : registered colour output
// -----------------------------------------------------------------------------
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int COL_W       = 10,
    parameter int ROW_W       = 10,
    parameter int H_ACTIVE    = 640,
    parameter int VIDEO_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   strobe,
    input  logic                   line_wrap,
    input  logic                   frame_wrap,
    input  logic [COL_W-1:0]       col_nx,
    input  logic [ROW_W-1:0]       row_nx,
    input  logic                   de_nx,
    input  logic [1:0]             pattern,
    output logic [VIDEO_WIDTH-1:0] red,
    output logic [VIDEO_WIDTH-1:0] grn,
    output logic [VIDEO_WIDTH-1:0] blu
);

    localparam int BAR_W  = H_ACTIVE / 8;
    localparam int BAR_CW = cnt_width(BAR_W);
    localparam logic [BAR_CW-1:0] BAR_LAST  = BAR_CW'(BAR_W - 1);
    localparam logic [COL_W-1:0]  H_ACT_END = COL_W'(H_ACTIVE);
    // Bit 3 masks; they collapse to zero when a counter has fewer than 4 bits.
    localparam logic [COL_W-1:0]  COL_B3    = COL_W'(32'd8);
    localparam logic [ROW_W-1:0]  ROW_B3    = ROW_W'(32'd8);

    pattern_t               pat_r;
    pattern_t               pat_nx_s;
    logic [BAR_CW-1:0]      bar_cnt_r;
    logic [BAR_CW-1:0]      bar_cnt_nx_s;
    logic [2:0]             bar_idx_r;
    logic [2:0]             bar_idx_nx_s;
    logic                   chk_s;
    logic [VIDEO_WIDTH-1:0] red_nx_s;
    logic [VIDEO_WIDTH-1:0] grn_nx_s;
    logic [VIDEO_WIDTH-1:0] blu_nx_s;
    logic [VIDEO_WIDTH-1:0] red_r;
    logic [VIDEO_WIDTH-1:0] grn_r;
    logic [VIDEO_WIDTH-1:0] blu_r;

    // Next pattern and bar position: bars are tracked by a pixel-in-bar counter
    // rather than dividing col, and stop advancing once past the active area.
    always_comb begin
        pat_nx_s     = pat_r;
        bar_cnt_nx_s = bar_cnt_r;
        bar_idx_nx_s = bar_idx_r;
        if (frame_wrap) begin
            pat_nx_s = pattern_t'(pattern);
        end else begin
            pat_nx_s = pat_r;
        end
        if (line_wrap) begin
            bar_cnt_nx_s = '0;
            bar_idx_nx_s = 3'd0;
        end else if (col_nx < H_ACT_END) begin
            if (bar_cnt_r == BAR_LAST) begin
                bar_cnt_nx_s = '0;
                bar_idx_nx_s = bar_idx_r + 3'd1;
            end else begin
                bar_cnt_nx_s = bar_cnt_r + BAR_CW'(1);
                bar_idx_nx_s = bar_idx_r;
            end
        end else begin
            bar_cnt_nx_s = bar_cnt_r;
            bar_idx_nx_s = bar_idx_r;
        end
    end

    // Colour for the next pixel, blanked outside active video.
    always_comb begin
        red_nx_s = '0;
        grn_nx_s = '0;
        blu_nx_s = '0;
        chk_s    = (|(col_nx & COL_B3)) ^ (|(row_nx & ROW_B3));
        case (pat_nx_s)
            PAT_BLACK: begin
                red_nx_s = '0;
                grn_nx_s = '0;
                blu_nx_s = '0;
            end
            PAT_BARS: begin
                red_nx_s = {VIDEO_WIDTH{bar_idx_nx_s[2]}};
                grn_nx_s = {VIDEO_WIDTH{bar_idx_nx_s[1]}};
                blu_nx_s = {VIDEO_WIDTH{bar_idx_nx_s[0]}};
            end
            PAT_CHECKER: begin
                red_nx_s = {VIDEO_WIDTH{chk_s}};
                grn_nx_s = {VIDEO_WIDTH{chk_s}};
                blu_nx_s = {VIDEO_WIDTH{chk_s}};
            end
            PAT_RED: begin
                red_nx_s = {VIDEO_WIDTH{1'b1}};
                grn_nx_s = '0;
                blu_nx_s = '0;
            end
            default: begin
                red_nx_s = '0;
                grn_nx_s = '0;
                blu_nx_s = '0;
            end
        endcase
        if (!de_nx) begin
            red_nx_s = '0;
            grn_nx_s = '0;
            blu_nx_s = '0;
        end else begin
            red_nx_s = red_nx_s;
        end
    end

    // Pattern latch, bar counters and colour registers advance only on strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            pat_r     <= PAT_BLACK;
            bar_cnt_r <= '0;
            bar_idx_r <= 3'd0;
            red_r     <= '0;
            grn_r     <= '0;
            blu_r     <= '0;
        end else if (strobe) begin
            pat_r     <= pat_nx_s;
            bar_cnt_r <= bar_cnt_nx_s;
            bar_idx_r <= bar_idx_nx_s;
            red_r     <= red_nx_s;
            grn_r     <= grn_nx_s;
            blu_r     <= blu_nx_s;
        end
    end

    assign red = red_r;
    assign grn = grn_r;
    assign blu = blu_r;

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// VGA raster timing generator with built-in test patterns. A divider produces
// a pixel strobe every CLK_DIV sysclk cycles (no derived clock); col/row step
// on each strobe and every output is registered at that same edge, so all
// outputs change together one sysclk after the strobe cycle.
//   sysclk   : the only clock
//   reset    : synchronous, active-high; wins over enable
//   enable   : 1 = run, 0 = freeze everything (frame_start forced low)
//   pattern  : 0 black, 1 colour bars, 2 checker, 3 solid red
//   vid      : video outputs (hsync, vsync, de, col, row, frame_start, RGB)
// -----------------------------------------------------------------------------
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV     = 11,
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter bit HSYNC_POL   = 1'b0,
    parameter bit VSYNC_POL   = 1'b0,
    parameter int VIDEO_WIDTH = 4
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] pattern,
    vga_timing_gen_if.master vid
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int COL_W   = cnt_width(H_TOTAL);
    localparam int ROW_W   = cnt_width(V_TOTAL);
    localparam int DIV_W   = cnt_width(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(H_TOTAL - 1);
    localparam logic [COL_W-1:0] HS_FIRST  = COL_W'(H_ACTIVE + H_FP);
    localparam logic [COL_W-1:0] HS_LAST   = COL_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [COL_W-1:0] H_ACT_END = COL_W'(H_ACTIVE);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(V_TOTAL - 1);
    localparam logic [ROW_W-1:0] VS_FIRST  = ROW_W'(V_ACTIVE + V_FP);
    localparam logic [ROW_W-1:0] VS_LAST   = ROW_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [ROW_W-1:0] V_ACT_END = ROW_W'(V_ACTIVE);

    logic [DIV_W-1:0] div_r;
    logic             strobe_s;
    logic [COL_W-1:0] col_r;
    logic [ROW_W-1:0] row_r;
    logic [COL_W-1:0] col_nx_s;
    logic [ROW_W-1:0] row_nx_s;
    logic             line_wrap_s;
    logic             frame_wrap_s;
    logic             hsync_nx_s;
    logic             vsync_nx_s;
    logic             de_nx_s;
    logic             hsync_r;
    logic             vsync_r;
    logic             de_r;
    logic             frame_start_r;

    assign strobe_s = enable && (div_r == DIV_LAST);

    // Pixel divider: counts 0..CLK_DIV-1 while enabled, holds while disabled.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            div_r <= '0;
        end else if (enable) begin
            if (div_r == DIV_LAST) begin
                div_r <= '0;
            end else begin
                div_r <= div_r + DIV_W'(1);
            end
        end
    end

    // Position after the next strobe, plus the sync/active decode of it so
    // the output registers load values that match the new counters.
    always_comb begin
        col_nx_s     = col_r + COL_W'(1);
        row_nx_s     = row_r;
        line_wrap_s  = 1'b0;
        frame_wrap_s = 1'b0;
        if (col_r == COL_LAST) begin
            col_nx_s    = '0;
            line_wrap_s = 1'b1;
            if (row_r == ROW_LAST) begin
                row_nx_s     = '0;
                frame_wrap_s = 1'b1;
            end else begin
                row_nx_s = row_r + ROW_W'(1);
            end
        end else begin
            col_nx_s = col_r + COL_W'(1);
        end
        hsync_nx_s = ((col_nx_s >= HS_FIRST) && (col_nx_s <= HS_LAST)) ? HSYNC_POL : ~HSYNC_POL;
        vsync_nx_s = ((row_nx_s >= VS_FIRST) && (row_nx_s <= VS_LAST)) ? VSYNC_POL : ~VSYNC_POL;
        de_nx_s    = (col_nx_s < H_ACT_END) && (row_nx_s < V_ACT_END);
    end

    // Counters and timing outputs load together on the strobe; frame_start
    // is only ever high for the single sysclk following the frame wrap.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            col_r         <= '0;
            row_r         <= '0;
            hsync_r       <= ~HSYNC_POL;
            vsync_r       <= ~VSYNC_POL;
            de_r          <= 1'b0;
            frame_start_r <= 1'b0;
        end else if (strobe_s) begin
            col_r         <= col_nx_s;
            row_r         <= row_nx_s;
            hsync_r       <= hsync_nx_s;
            vsync_r       <= vsync_nx_s;
            de_r          <= de_nx_s;
            frame_start_r <= frame_wrap_s;
        end else begin
            frame_start_r <= 1'b0;
        end
    end

    vga_pattern_gen #(
        .COL_W       (COL_W),
        .ROW_W       (ROW_W),
        .H_ACTIVE    (H_ACTIVE),
        .VIDEO_WIDTH (VIDEO_WIDTH)
    ) u_pattern (
        .clk        (sysclk),
        .reset      (reset),
        .strobe     (strobe_s),
        .line_wrap  (line_wrap_s),
        .frame_wrap (frame_wrap_s),
        .col_nx     (col_nx_s),
        .row_nx     (row_nx_s),
        .de_nx      (de_nx_s),
        .pattern    (pattern),
        .red        (vid.red),
        .grn        (vid.grn),
        .blu        (vid.blu)
    );

    assign vid.hsync       = hsync_r;
    assign vid.vsync       = vsync_r;
    assign vid.de          = de_r;
    assign vid.col         = col_r;
    assign vid.row         = row_r;
    assign vid.frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
// Three generators on the small 10x6 raster (H 8/1/1/0, V 4/1/1/0):
//   dut_a : CLK_DIV=11, sync polarity 0
//   dut_b : CLK_DIV=1,  sync polarity 0
//   dut_c : CLK_DIV=11, sync polarity 1
// Inputs are shared; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

    logic       sysclk = 1'b0;
    logic       reset;
    logic       enable;
    logic [1:0] pattern;

    int checks = 0;
    int passes = 0;

    vga_timing_gen_if #(.COL_W(4), .ROW_W(3), .VIDEO_WIDTH(4)) va ();
    vga_timing_gen_if #(.COL_W(4), .ROW_W(3), .VIDEO_WIDTH(4)) vb ();
    vga_timing_gen_if #(.COL_W(4), .ROW_W(3), .VIDEO_WIDTH(4)) vc ();

    vga_timing_gen #(
        .CLK_DIV(11), .H_ACTIVE(8), .H_FP(1), .H_SYNC(1), .H_BP(0),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(0),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .VIDEO_WIDTH(4)
    ) dut_a (.sysclk(sysclk), .reset(reset), .enable(enable), .pattern(pattern), .vid(va));

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(8), .H_FP(1), .H_SYNC(1), .H_BP(0),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(0),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .VIDEO_WIDTH(4)
    ) dut_b (.sysclk(sysclk), .reset(reset), .enable(enable), .pattern(pattern), .vid(vb));

    vga_timing_gen #(
        .CLK_DIV(11), .H_ACTIVE(8), .H_FP(1), .H_SYNC(1), .H_BP(0),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(0),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .VIDEO_WIDTH(4)
    ) dut_c (.sysclk(sysclk), .reset(reset), .enable(enable), .pattern(pattern), .vid(vc));

    always #5 sysclk = ~sysclk;

    function automatic logic [22:0] snap_b();
        return {vb.hsync, vb.vsync, vb.de, vb.frame_start, vb.col, vb.row, vb.red, vb.grn, vb.blu};
    endfunction

    task automatic test_reset();
        reset   = 1'b1;
        enable  = 1'b1;
        pattern = 2'd0;
        repeat (3) @(posedge sysclk);
        @(negedge sysclk);
        checks++;
        if ({va.hsync, va.vsync, va.de, va.frame_start} !== 4'b1100) $display("FAIL reset_a_ctrl: got %b expected 1100", {va.hsync, va.vsync, va.de, va.frame_start});
        else passes++;
        checks++;
        if ({va.col, va.row} !== 7'd0) $display("FAIL reset_a_pos: got col=%0d row=%0d expected 0,0", va.col, va.row);
        else passes++;
        checks++;
        if ({va.red, va.grn, va.blu} !== 12'h000) $display("FAIL reset_a_rgb: got %h expected 000", {va.red, va.grn, va.blu});
        else passes++;
        checks++;
        if ({vc.hsync, vc.vsync, vc.de, vc.frame_start} !== 4'b0000) $display("FAIL reset_c_ctrl: got %b expected 0000", {vc.hsync, vc.vsync, vc.de, vc.frame_start});
        else passes++;
    endtask

    task automatic test_sync_timing();
        int cnt = 0;
        int hs_a = 0, vs_a = 0, hs_c = 0, vs_c = 0, fs_n = 0, bad = 0;
        reset = 1'b0;
        while (va.frame_start !== 1'b1 && cnt < 8000) begin
            @(negedge sysclk);
            cnt++;
        end
        checks++;
        if (cnt >= 8000) $display("FAIL sync_first_fs: got timeout after %0d cycles expected a frame_start", cnt);
        else passes++;
        for (int k = 0; k < 660; k++) begin
            if (va.hsync === 1'b0) hs_a++;
            if (va.vsync === 1'b0) vs_a++;
            if (vc.hsync === 1'b1) hs_c++;
            if (vc.vsync === 1'b1) vs_c++;
            if (va.frame_start === 1'b1) fs_n++;
            if ((va.hsync === 1'b0) != (va.col === 4'd9)) bad++;
            if ((va.vsync === 1'b0) != (va.row === 3'd5)) bad++;
            if ((vc.hsync === 1'b1) != (vc.col === 4'd9)) bad++;
            if ((vc.vsync === 1'b1) != (vc.row === 3'd5)) bad++;
            if (va.de !== ((va.col < 4'd8) && (va.row < 3'd4))) bad++;
            @(negedge sysclk);
        end
        checks++;
        if (hs_a != 66) $display("FAIL hsync_a_len: got %0d expected 66", hs_a);
        else passes++;
        checks++;
        if (vs_a != 110) $display("FAIL vsync_a_len: got %0d expected 110", vs_a);
        else passes++;
        checks++;
        if (hs_c != 66) $display("FAIL hsync_c_len: got %0d expected 66", hs_c);
        else passes++;
        checks++;
        if (vs_c != 110) $display("FAIL vsync_c_len: got %0d expected 110", vs_c);
        else passes++;
        checks++;
        if (fs_n != 1) $display("FAIL fs_count: got %0d expected 1", fs_n);
        else passes++;
        checks++;
        if (bad != 0) $display("FAIL sync_position: got %0d bad samples expected 0", bad);
        else passes++;
        checks++;
        if (va.frame_start !== 1'b1) $display("FAIL fs_period: got %b expected 1 at cycle 660", va.frame_start);
        else passes++;
    endtask

    task automatic test_bars();
        int cnt = 0;
        logic [2:0]  kb;
        logic [11:0] exp_rgb;
        pattern = 2'd1;
        @(negedge sysclk);
        while (vb.frame_start !== 1'b1 && cnt < 200) begin
            @(negedge sysclk);
            cnt++;
        end
        checks++;
        if (cnt >= 200) $display("FAIL bars_fs: got timeout expected a frame_start");
        else passes++;
        for (int k = 0; k < 10; k++) begin
            kb = 3'(k);
            exp_rgb = (k < 8) ? {{4{kb[2]}}, {4{kb[1]}}, {4{kb[0]}}} : 12'h000;
            checks++;
            if ({vb.col, vb.row, vb.red, vb.grn, vb.blu} !== {4'(k), 3'd0, exp_rgb})
                $display("FAIL bars_col%0d: got col=%0d row=%0d rgb=%h expected col=%0d row=0 rgb=%h",
                         k, vb.col, vb.row, {vb.red, vb.grn, vb.blu}, k, exp_rgb);
            else passes++;
            @(negedge sysclk);
        end
    endtask

    task automatic test_pattern_change();
        int cnt = 0;
        while (vb.row !== 3'd2 && cnt < 100) begin
            @(negedge sysclk);
            cnt++;
        end
        pattern = 2'd3;
        while (!(vb.row === 3'd3 && vb.col === 4'd1) && cnt < 200) begin
            @(negedge sysclk);
            cnt++;
        end
        checks++;
        if ({vb.de, vb.red, vb.grn, vb.blu} !== {1'b1, 12'h00F}) $display("FAIL change_midframe: got de=%b rgb=%h expected de=1 rgb=00f", vb.de, {vb.red, vb.grn, vb.blu});
        else passes++;
        while (vb.frame_start !== 1'b1 && cnt < 300) begin
            @(negedge sysclk);
            cnt++;
        end
        checks++;
        if ({vb.col, vb.row, vb.red, vb.grn, vb.blu} !== {4'd0, 3'd0, 12'hF00}) $display("FAIL change_newframe: got col=%0d row=%0d rgb=%h expected 0,0 f00", vb.col, vb.row, {vb.red, vb.grn, vb.blu});
        else passes++;
        @(negedge sysclk);
        checks++;
        if ({vb.col, vb.red, vb.grn, vb.blu} !== {4'd1, 12'hF00}) $display("FAIL change_col1: got col=%0d rgb=%h expected 1 f00", vb.col, {vb.red, vb.grn, vb.blu});
        else passes++;
    endtask

    task automatic test_enable_hold();
        int cnt = 0, bad = 0;
        logic [22:0] held;
        while (!(vb.col === 4'd4 && vb.row === 3'd1) && cnt < 100) begin
            @(negedge sysclk);
            cnt++;
        end
        checks++;
        if (cnt >= 100) $display("FAIL hold_reach: got timeout expected col=4 row=1");
        else passes++;
        held = snap_b();
        enable = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge sysclk);
            if (snap_b() !== held) bad++;
            if (vb.frame_start !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) $display("FAIL hold_frozen: got %0d changed samples expected 0", bad);
        else passes++;
        enable = 1'b1;
        @(negedge sysclk);
        checks++;
        if ({vb.col, vb.row} !== {4'd5, 3'd1}) $display("FAIL hold_resume: got col=%0d row=%0d expected 5,1", vb.col, vb.row);
        else passes++;
    endtask

    task automatic test_reset_midframe();
        int cnt = 0;
        while (!(vb.col === 4'd6 && vb.row === 3'd3) && cnt < 100) begin
            @(negedge sysclk);
            cnt++;
        end
        reset = 1'b1;
        @(negedge sysclk);
        checks++;
        if ({vb.hsync, vb.vsync, vb.de, vb.frame_start, vb.col, vb.row, vb.red, vb.grn, vb.blu} !== {4'b1100, 4'd0, 3'd0, 12'h000})
            $display("FAIL midreset_vals: got %h expected %h", snap_b(), {4'b1100, 4'd0, 3'd0, 12'h000});
        else passes++;
        @(negedge sysclk);
        reset = 1'b0;
        @(negedge sysclk);
        checks++;
        if ({vb.col, vb.row, vb.frame_start} !== {4'd1, 3'd0, 1'b0}) $display("FAIL midreset_first: got col=%0d row=%0d fs=%b expected 1,0,0", vb.col, vb.row, vb.frame_start);
        else passes++;
        checks++;
        if ({vb.de, vb.red, vb.grn, vb.blu} !== {1'b1, 12'h000}) $display("FAIL midreset_black: got de=%b rgb=%h expected de=1 rgb=000", vb.de, {vb.red, vb.grn, vb.blu});
        else passes++;
        cnt = 0;
        while (vb.frame_start !== 1'b1 && cnt < 200) begin
            @(negedge sysclk);
            cnt++;
        end
        checks++;
        if (cnt != 59) $display("FAIL midreset_fs: got %0d cycles expected 59", cnt);
        else passes++;
        checks++;
        if ({vb.red, vb.grn, vb.blu} !== 12'hF00) $display("FAIL midreset_latch: got rgb=%h expected f00", {vb.red, vb.grn, vb.blu});
        else passes++;
    endtask

    initial begin
        test_reset();
        test_sync_timing();
        test_bars();
        test_pattern_change();
        test_enable_hold();
        test_reset_midframe();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
